puf_challenge_sequencer: RTL and testbench

Initiator-side controller for the ring-oscillator PUF array. It walks a sequence of challenge pairs and, for each pair, drives the oscillator mux selects, the counter reset and the oscillator/counter enables, and times a fixed measurement window. It then compares the two returned 12-bit frequency counts and shifts the resulting bit into a response word. It replaces manual VIO driving of select1/select2/enable/reset, and hands a complete NUM_BITS response to downstream logic through a valid/ack handshake.

---
 rtl/puf_challenge_sequencer.sv | 139 +++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - ring-oscillator PUF challenge sequencer
// Walks challenge pairs, times each measurement window and builds the response word.
module puf_challenge_sequencer #(
    parameter int NUM_BITS = 16,
    parameter int WINDOW   = 4095,
    parameter int SETTLE   = 2,
    parameter int HOLD     = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          stride,
    output logic [3:0]          select1,
    output logic [3:0]          select2,
    output logic                ro_enable,
    output logic                ctr_reset,
    output logic                ctr_enable,
    input  logic [11:0]         count1,
    input  logic [11:0]         count2,
    output logic                busy,
    output logic [NUM_BITS-1:0] response,
    output logic [NUM_BITS-1:0] tie_mask,
    output logic                sat,
    output logic                response_valid,
    input  logic                response_ack
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        MEASURE,
        HOLDOFF,
        SAMPLE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] timer;
    logic        timer_done;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic [3:0]  stride_eff;
    logic        last_bit;

    assign stride_eff = (stride == 4'd0) ? 4'd1 : stride;
    assign last_bit   = (idx == 4'(NUM_BITS - 1));

    // One shared timer measures the settle, window and hold phases; it restarts on every state change.
    always_comb begin
        timer_done = 1'b0;
        case (state)
            SELECT:  timer_done = (timer == 12'(SETTLE - 1));
            MEASURE: timer_done = (timer == 12'(WINDOW - 1));
            HOLDOFF: timer_done = (timer == 12'(HOLD - 1));
            default: timer_done = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SELECT;
                    idx_next   = 4'd0;
                end
            end
            SELECT:  if (timer_done) state_next = MEASURE;
            MEASURE: if (timer_done) state_next = HOLDOFF;
            HOLDOFF: if (timer_done) state_next = SAMPLE;
            SAMPLE: begin
                if (last_bit) begin
                    state_next = DONE;
                end else begin
                    state_next = SELECT;
                    idx_next   = idx + 4'd1;
                end
            end
            DONE:    if (response_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change with the state itself.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            timer          <= 12'd0;
            idx            <= 4'd0;
            select1        <= 4'd0;
            select2        <= 4'd0;
            ro_enable      <= 1'b0;
            ctr_reset      <= 1'b1;
            ctr_enable     <= 1'b0;
            busy           <= 1'b0;
            response       <= '0;
            tie_mask       <= '0;
            sat            <= 1'b0;
            response_valid <= 1'b0;
        end else begin
            state <= state_next;
            timer <= (state_next != state) ? 12'd0 : timer + 12'd1;

            if (state_next == SELECT && state != SELECT) begin
                idx     <= idx_next;
                select1 <= idx_next;
                select2 <= idx_next + stride_eff;
            end

            if (state == IDLE && start) begin
                response <= '0;
                tie_mask <= '0;
                sat      <= 1'b0;
            end

            if (state == SAMPLE) begin
                for (int i = 0; i < NUM_BITS; i++) begin
                    if (idx == 4'(i)) begin
                        response[i] <= (count1 > count2);
                        tie_mask[i] <= (count1 == count2);
                    end
                end
                sat <= sat | (count1 == 12'hFFF) | (count2 == 12'hFFF);
            end

            busy           <= (state_next == SELECT) || (state_next == MEASURE) ||
                              (state_next == HOLDOFF) || (state_next == SAMPLE);
            ro_enable      <= (state_next == MEASURE) || (state_next == HOLDOFF) ||
                              (state_next == SAMPLE);
            ctr_reset      <= (state_next == IDLE) || (state_next == SELECT) ||
                              (state_next == DONE);
            ctr_enable     <= (state_next == MEASURE);
            response_valid <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - scoreboard bench for puf_challenge_sequencer
module tb_puf_challenge_sequencer;

    typedef struct packed {
        logic [15:0] resp;
        logic [15:0] tie;
        logic        sat;
    } result_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0, ack_a = 1'b0;
    logic [3:0]  stride_a = 4'd1;
    logic [3:0]  select1_a, select2_a;
    logic        ro_enable_a, ctr_reset_a, ctr_enable_a, busy_a, sat_a, valid_a;
    logic [11:0] count1_a, count2_a;
    logic [15:0] response_a, tie_mask_a;

    logic        start_b = 1'b0, ack_b = 1'b0;
    logic [3:0]  stride_b = 4'd1;
    logic [3:0]  select1_b, select2_b;
    logic        ro_enable_b, ctr_reset_b, ctr_enable_b, busy_b, sat_b, valid_b;
    logic [11:0] count1_b, count2_b;
    logic [15:0] response_b, tie_mask_b;
    int          mode_b = 1;

    int          n_checks = 0;
    int          n_fail = 0;
    result_t     exp_q[$];
    logic [7:0]  pair_q[$];
    result_t     last_exp;

    always #5 clock = ~clock;

    puf_challenge_sequencer dut_a (
        .clock(clock), .reset(reset), .start(start_a), .stride(stride_a),
        .select1(select1_a), .select2(select2_a), .ro_enable(ro_enable_a),
        .ctr_reset(ctr_reset_a), .ctr_enable(ctr_enable_a),
        .count1(count1_a), .count2(count2_a), .busy(busy_a),
        .response(response_a), .tie_mask(tie_mask_a), .sat(sat_a),
        .response_valid(valid_a), .response_ack(ack_a)
    );

    puf_challenge_sequencer #(.NUM_BITS(16), .WINDOW(8), .SETTLE(2), .HOLD(2)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .stride(stride_b),
        .select1(select1_b), .select2(select2_b), .ro_enable(ro_enable_b),
        .ctr_reset(ctr_reset_b), .ctr_enable(ctr_enable_b),
        .count1(count1_b), .count2(count2_b), .busy(busy_b),
        .response(response_b), .tie_mask(tie_mask_b), .sat(sat_b),
        .response_valid(valid_b), .response_ack(ack_b)
    );

    // Oscillator count models: returns {count1, count2} for a select pair.
    function automatic logic [23:0] model(input int mode, input logic [3:0] s1, input logic [3:0] s2);
        logic [11:0] c1, c2;
        case (mode)
            0: begin c1 = 12'd100 + 12'(s1); c2 = 12'd100 + 12'(s1); end
            1: begin c1 = 12'(s1) * 12'd10; c2 = 12'(s2) * 12'd10; end
            2: begin c1 = (s1 == 4'd15) ? 12'd200 : 12'd100; c2 = 12'd150; end
            default: begin c1 = 12'(s1) * 12'd10; c2 = (s1 == 4'd2) ? 12'hFFF : 12'(s2) * 12'd10; end
        endcase
        return {c1, c2};
    endfunction

    always_comb {count1_a, count2_a} = model(0, select1_a, select2_a);
    always_comb {count1_b, count2_b} = model(mode_b, select1_b, select2_b);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_expect(input int mode, input logic [3:0] stride, input bit pairs);
        result_t    r;
        logic [3:0] s1, s2, st;
        logic [11:0] c1, c2;
        r  = '0;
        st = (stride == 4'd0) ? 4'd1 : stride;
        for (int i = 0; i < 16; i++) begin
            s1 = 4'(i);
            s2 = 4'((i + int'(st)) % 16);
            {c1, c2} = model(mode, s1, s2);
            r.resp[i] = (c1 > c2);
            r.tie[i]  = (c1 == c2);
            if (c1 == 12'hFFF || c2 == 12'hFFF) r.sat = 1'b1;
            if (pairs) pair_q.push_back({s1, s2});
        end
        exp_q.push_back(r);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({select1_a, select2_a, ro_enable_a, ctr_reset_a, ctr_enable_a, busy_a, valid_a, sat_a} !== {8'h00, 6'b010000}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got sel=%h/%h ro=%b cr=%b ce=%b busy=%b valid=%b sat=%b expected zeros with ctr_reset=1",
                     select1_a, select2_a, ro_enable_a, ctr_reset_a, ctr_enable_a, busy_a, valid_a, sat_a);
        end
        n_checks++;
        if ({response_a, tie_mask_a, response_b, tie_mask_b} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_words: got %h %h %h %h expected 0", response_a, tie_mask_a, response_b, tie_mask_b);
        end
    endtask

    task automatic test_default_ties();
        result_t e;
        int      n;
        stride_a = 4'd1;
        start_a  = 1'b1;
        push_expect(0, 4'd1, 1'b0);
        tick();
        start_a = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1 || ctr_reset_a !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: got busy=%b ctr_reset=%b expected 1 1", busy_a, ctr_reset_a);
        end
        n = 0;
        while (!valid_a && n < 70000) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 65600) begin
            n_fail++;
            $display("FAIL default_run_len: got %0d cycles expected 65600", n);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({response_a, tie_mask_a, sat_a} !== {e.resp, e.tie, e.sat} || e.tie !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL default_result: got resp=%h tie=%h sat=%b expected resp=%h tie=%h sat=%b",
                     response_a, tie_mask_a, sat_a, e.resp, e.tie, e.sat);
        end
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        n_checks++;
        if (valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL default_ack: got valid=%b expected 0", valid_a);
        end
    endtask

    // Follows one run of dut_b bit by bit, checking selects and window length, then the result.
    task automatic run_and_check_b(input bit poke_start);
        result_t    e;
        logic [7:0] p;
        int         t;
        for (int b = 0; b < 16; b++) begin
            t = 0;
            while (!ctr_enable_b && t < 100) begin
                tick();
                t++;
            end
            p = pair_q.pop_front();
            n_checks++;
            if ({select1_b, select2_b} !== p || t >= 100 || ro_enable_b !== 1'b1 || ctr_reset_b !== 1'b0) begin
                n_fail++;
                $display("FAIL bit%0d_pair: got sel=%h/%h ro=%b cr=%b wait=%0d expected sel=%h/%h ro=1 cr=0",
                         b, select1_b, select2_b, ro_enable_b, ctr_reset_b, t, p[7:4], p[3:0]);
            end
            t = 0;
            while (ctr_enable_b && t < 100) begin
                if (poke_start && b == 1 && t == 2) start_b = 1'b1;
                tick();
                start_b = 1'b0;
                t++;
            end
            n_checks++;
            if (t !== 8) begin
                n_fail++;
                $display("FAIL bit%0d_window: got %0d cycles expected 8", b, t);
            end
        end
        t = 0;
        while (!valid_b && t < 100) begin
            tick();
            t++;
        end
        e = exp_q.pop_front();
        last_exp = e;
        n_checks++;
        if ({response_b, tie_mask_b, sat_b, valid_b, busy_b, ro_enable_b} !== {e.resp, e.tie, e.sat, 3'b100}) begin
            n_fail++;
            $display("FAIL run_result: got resp=%h tie=%h sat=%b valid=%b busy=%b ro=%b expected resp=%h tie=%h sat=%b valid=1 busy=0 ro=0",
                     response_b, tie_mask_b, sat_b, valid_b, busy_b, ro_enable_b, e.resp, e.tie, e.sat);
        end
    endtask

    task automatic ack_b_run();
        ack_b = 1'b1;
        tick();
        ack_b = 1'b0;
        n_checks++;
        if (valid_b !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_b: got valid=%b busy=%b expected 0 0", valid_b, busy_b);
        end
    endtask

    task automatic test_stride();
        mode_b   = 1;
        stride_b = 4'd5;
        start_b  = 1'b1;
        push_expect(1, 4'd5, 1'b1);
        tick();
        start_b = 1'b0;
        run_and_check_b(1'b1);
        ack_b_run();
    endtask

    task automatic test_stride_zero();
        mode_b   = 2;
        stride_b = 4'd0;
        start_b  = 1'b1;
        push_expect(2, 4'd0, 1'b1);
        tick();
        start_b = 1'b0;
        run_and_check_b(1'b0);
        n_checks++;
        if (response_b !== 16'h8000) begin
            n_fail++;
            $display("FAIL stride_zero_resp: got %h expected 8000", response_b);
        end
        ack_b_run();
    endtask

    task automatic test_reset_midrun();
        int t;
        mode_b   = 3;
        stride_b = 4'd1;
        start_b  = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (!ctr_enable_b && t < 100) begin tick(); t++; end
            if (k == 0) while (ctr_enable_b && t < 200) begin tick(); t++; end
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({ctr_reset_b, busy_b, ctr_enable_b, ro_enable_b, valid_b, response_b, tie_mask_b} !== {5'b10000, 32'h0} || t >= 100) begin
            n_fail++;
            $display("FAIL midrun_reset: got cr=%b busy=%b ce=%b ro=%b valid=%b resp=%h tie=%h expected cr=1 others 0",
                     ctr_reset_b, busy_b, ctr_enable_b, ro_enable_b, valid_b, response_b, tie_mask_b);
        end
        start_b = 1'b1;
        push_expect(3, 4'd1, 1'b1);
        tick();
        start_b = 1'b0;
        run_and_check_b(1'b0);
    endtask

    task automatic test_valid_hold();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({valid_b, response_b, tie_mask_b, sat_b} !== {1'b1, last_exp.resp, last_exp.tie, last_exp.sat} || last_exp.sat !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_%0d: got valid=%b resp=%h tie=%h sat=%b expected valid=1 resp=%h tie=%h sat=1",
                         i, valid_b, response_b, tie_mask_b, sat_b, last_exp.resp, last_exp.tie);
            end
        end
    endtask

    task automatic test_ack_with_start();
        ack_b   = 1'b1;
        start_b = 1'b1;
        tick();
        ack_b   = 1'b0;
        start_b = 1'b0;
        n_checks++;
        if (valid_b !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_start: got valid=%b busy=%b expected 0 0", valid_b, busy_b);
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (busy_b !== 1'b0 || ctr_reset_b !== 1'b1 || valid_b !== 1'b0) begin
            n_fail++;
            $display("FAIL no_restart: got busy=%b cr=%b valid=%b expected 0 1 0", busy_b, ctr_reset_b, valid_b);
        end
    endtask

    initial begin
        test_reset();
        test_default_ties();
        test_stride();
        test_stride_zero();
        test_reset_midrun();
        test_valid_hold();
        test_ack_with_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
